// File: rtl/hold_ctrl.sv
// rtl/hold_ctrl.sv - pipeline hold/flush scheduler (optional bus-wait timeout under HOLD_TIMEOUT_EN)
module hold_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ifetch_wait_i,
  input  logic       load_use_i,
  input  logic       jmp_taken_i,
  input  logic       mdu_start_i,
  input  logic       mdu_done_i,
  input  logic       dmem_wait_i,
  input  logic       trap_i,
  output logic [2:0] hold_code_o,
  output logic       flush_if_o,
  output logic       flush_id_o,
  output logic       bus_timeout_o
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_LDSTALL = 2'd1;
  localparam logic [1:0] S_MDU     = 2'd2;
  localparam logic [1:0] S_TRAP    = 2'd3;

  localparam logic [2:0] H_NONE = 3'd0;
  localparam logic [2:0] H_PC   = 3'd1;
  localparam logic [2:0] H_IF   = 3'd2;
  localparam logic [2:0] H_ID   = 3'd3;
  localparam logic [2:0] H_EX   = 3'd4;
  localparam logic [2:0] H_MEM  = 3'd5;

  // The wait counter must be able to reach the timeout value.
  if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_cfg_check
    $error("hold_ctrl: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  logic [1:0] state_q, state_d;
  logic [2:0] hold_c;
  logic       flush_if_c, flush_id_c;
  logic       ld_honour;

  // State register; reset lands in RUN immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // Hold code is the max of active requests; flushes and next state follow the priority order.
  always_comb begin
    hold_c     = H_NONE;
    flush_if_c = 1'b0;
    flush_id_c = 1'b0;
    ld_honour  = 1'b0;
    state_d    = state_q;
    if (trap_i) begin
      flush_if_c = 1'b1;
      flush_id_c = 1'b1;
      state_d    = S_TRAP;
    end else if (state_q == S_TRAP) begin
      // Second cycle of the trap flush.
      flush_if_c = 1'b1;
      flush_id_c = 1'b1;
      state_d    = S_RUN;
    end else begin
      if (ifetch_wait_i)                          hold_c = H_PC;
      if (load_use_i && state_q == S_RUN)         hold_c = H_IF;
      if (state_q == S_MDU && !mdu_done_i)        hold_c = H_EX;
      if (dmem_wait_i)                            hold_c = H_MEM;
      // A starting MDU op outranks the load-use bubble for the transition.
      ld_honour = (state_q == S_RUN) && load_use_i && !dmem_wait_i && !mdu_start_i;
      if (!dmem_wait_i) begin
        flush_id_c = ld_honour;
        flush_if_c = ifetch_wait_i || (jmp_taken_i && (hold_c < H_ID) && !ld_honour);
        case (state_q)
          S_RUN: begin
            if (mdu_start_i)     state_d = S_MDU;
            else if (load_use_i) state_d = S_LDSTALL;
          end
          S_LDSTALL: state_d = S_RUN;
          S_MDU:     if (mdu_done_i) state_d = S_RUN;
          default:   state_d = S_RUN;
        endcase
      end
    end
  end

  assign hold_code_o = rst ? H_NONE : hold_c;
  assign flush_if_o  = !rst && flush_if_c;
  assign flush_id_o  = !rst && flush_id_c;

`ifdef HOLD_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit;

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Count consecutive bus-wait cycles; clear on timeout, trap or any cycle without a wait.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (timeout_hit || trap_i || !(ifetch_wait_i || dmem_wait_i)) cnt_d = '0;
  end

  // Wait counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bus_timeout_o = !rst && timeout_hit;
`else
  assign bus_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_hold_ctrl.sv
// tb/tb_hold_ctrl.sv - randomized self-checking bench for hold_ctrl against a behavioural model
module tb_hold_ctrl;
  localparam int TB_TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ifetch_wait_i, load_use_i, jmp_taken_i, mdu_start_i, mdu_done_i, dmem_wait_i, trap_i;
  logic [2:0] hold_code_o;
  logic       flush_if_o, flush_id_o, bus_timeout_o;

  int checks = 0;
  int failures = 0;

  // Model of pipeline occupancy: an MDU op in flight, a load-use bubble just issued,
  // the trailing cycle of a trap flush, and the length of the current bus-wait run.
  bit m_mdu_busy, m_bubble, m_trap_tail;
  int m_wait_run;

  hold_ctrl #(.TIMEOUT_CYCLES(TB_TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifetch_wait_i(ifetch_wait_i), .load_use_i(load_use_i), .jmp_taken_i(jmp_taken_i),
    .mdu_start_i(mdu_start_i), .mdu_done_i(mdu_done_i), .dmem_wait_i(dmem_wait_i),
    .trap_i(trap_i), .hold_code_o(hold_code_o), .flush_if_o(flush_if_o),
    .flush_id_o(flush_id_o), .bus_timeout_o(bus_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Apply one cycle of inputs (called at negedge), check outputs, then advance the model.
  task automatic step(input bit ifw, input bit lu, input bit jmp, input bit ms,
                      input bit md, input bit dw, input bit tr, input int xh);
    int  eh;
    bit  efi, efd, eto, running, honour;
    ifetch_wait_i = ifw; load_use_i = lu; jmp_taken_i = jmp; mdu_start_i = ms;
    mdu_done_i = md; dmem_wait_i = dw; trap_i = tr;
    #1;
    running = !m_mdu_busy && !m_bubble && !m_trap_tail;
    honour  = 1'b0;
    if (tr || m_trap_tail) begin
      eh = 0; efi = 1'b1; efd = 1'b1;
    end else begin
      eh = 0;
      if (ifw)              eh = imax(eh, 1);
      if (running && lu)    eh = imax(eh, 2);
      if (m_mdu_busy && !md) eh = imax(eh, 4);
      if (dw)               eh = imax(eh, 5);
      honour = running && lu && !dw && !ms;
      if (dw) begin
        efi = 1'b0; efd = 1'b0;
      end else begin
        efd = honour;
        efi = ifw || (jmp && eh < 3 && !honour);
      end
    end
`ifdef HOLD_TIMEOUT_EN
    eto = (m_wait_run == TB_TO);
`else
    eto = 1'b0;
`endif
    chk_eq("hold", int'(hold_code_o), eh);
    chk_eq("flush_if", int'(flush_if_o), int'(efi));
    chk_eq("flush_id", int'(flush_id_o), int'(efd));
    chk_eq("timeout", int'(bus_timeout_o), int'(eto));
    if (xh >= 0) chk_eq("hold_plan", int'(hold_code_o), xh);
    @(posedge clk);
    if (eto || tr || !(ifw || dw)) m_wait_run = 0;
    else                           m_wait_run++;
    if (tr) begin
      m_trap_tail = 1'b1; m_mdu_busy = 1'b0; m_bubble = 1'b0;
    end else if (m_trap_tail) begin
      m_trap_tail = 1'b0;
    end else if (!dw) begin
      if (m_mdu_busy)   m_mdu_busy = !md;
      else if (m_bubble) m_bubble = 1'b0;
      else if (ms)      m_mdu_busy = 1'b1;
      else if (lu)      m_bubble = 1'b1;
    end
    @(negedge clk);
  endtask

  // Assert reset (at negedge) with every input high; outputs must be 0 at once.
  task automatic do_reset();
    rst = 1'b1;
    {ifetch_wait_i, load_use_i, jmp_taken_i, mdu_start_i, mdu_done_i, dmem_wait_i, trap_i} = '1;
    #1;
    chk_eq("rst_hold", int'(hold_code_o), 0);
    chk_eq("rst_fif", int'(flush_if_o), 0);
    chk_eq("rst_fid", int'(flush_id_o), 0);
    chk_eq("rst_tmo", int'(bus_timeout_o), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    {ifetch_wait_i, load_use_i, jmp_taken_i, mdu_start_i, mdu_done_i, dmem_wait_i, trap_i} = '0;
    m_mdu_busy = 1'b0; m_bubble = 1'b0; m_trap_tail = 1'b0; m_wait_run = 0;
  endtask

  initial begin
    rst = 1'b0;
    {ifetch_wait_i, load_use_i, jmp_taken_i, mdu_start_i, mdu_done_i, dmem_wait_i, trap_i} = '0;
    @(negedge clk);
    do_reset();
    step(0,0,0,0,0,0,0, 0);

    // Load-use: one bubble, then unheld.
    step(0,1,0,0,0,0,0, 2);
    step(0,1,0,0,0,0,0, 0);
    step(0,0,0,0,0,0,0, 0);

    // Load-use followed by a 3-cycle data wait; still a single bubble.
    step(0,1,0,0,0,0,0, 2);
    for (int i = 0; i < 3; i++) step(0,1,0,0,0,1,0, 5);
    step(0,1,0,0,0,0,0, 0);
    step(0,0,0,0,0,0,0, 0);

    // MDU start at t0, done at t5, jump at t3 must not flush.
    step(0,0,0,1,0,0,0, 0);
    step(0,0,0,0,0,0,0, 4);
    step(0,0,0,0,0,0,0, 4);
    step(0,0,1,0,0,0,0, 4);
    step(0,0,0,0,0,0,0, 4);
    step(0,0,0,0,1,0,0, 0);

    // Trap during MDU at t2: two flush cycles, then RUN.
    step(0,0,0,1,0,0,0, 0);
    step(0,0,0,0,0,0,0, 4);
    step(0,0,0,0,0,0,1, 0);
    step(0,0,0,0,0,0,0, 0);
    step(0,0,0,0,0,0,0, 0);

    // Long data wait: exercises the timeout pulse when enabled.
    for (int i = 0; i < 10; i++) step(0,0,0,0,0,1,0, 5);
    step(0,0,0,0,0,0,0, 0);

    // Randomized traffic with occasional asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      step($urandom_range(0,3) == 0, $urandom_range(0,3) == 0, $urandom_range(0,3) == 0,
           $urandom_range(0,5) == 0, $urandom_range(0,3) == 0, $urandom_range(0,4) == 0,
           $urandom_range(0,19) == 0, -1);
    end
    // Mid-run reset must also clear outputs immediately.
    step(0,0,0,1,0,0,0, -1);
    do_reset();
    step(0,0,0,0,0,0,0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
